// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM port between a hard-timed CPU slot and two DMA requesters
// (video fetch, loader write). DMA may only use the gaps that cannot collide with the next CPU slot.
module ram_arbiter #(
    parameter int PERIOD = 25,
    parameter int GUARD  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_slot,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_done,
    input  logic        vic_req,
    input  logic [15:0] vic_addr,
    output logic        vic_ack,
    output logic [7:0]  vic_rdata,
    input  logic        ldr_req,
    input  logic [15:0] ldr_addr,
    input  logic [7:0]  ldr_wdata,
    output logic        ldr_ack,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic        overrun,
    output logic [2:0]  dbg_state,
    output logic [((PERIOD > 1) ? $clog2(PERIOD) : 1)-1:0] dbg_phase
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] LAST  = PW'(PERIOD - 1);
    localparam logic [PW-1:0] LIMIT = PW'(PERIOD - GUARD);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CPU_ACC = 3'd1,
        CPU_CAP = 3'd2,
        DMA_ACC = 3'd3,
        DMA_CAP = 3'd4
    } state_t;

    state_t        state_q;
    logic [PW-1:0] phase_q, phase_d;
    logic          prio_ldr_q;   // 1: loader wins a tie (VIC completed most recently)
    logic          owner_ldr_q;  // requester owning the in-flight DMA access
    logic [15:0]   ram_addr_q;
    logic          ram_we_q;
    logic [7:0]    ram_din_q;
    logic [7:0]    cpu_rdata_q, vic_rdata_q;
    logic          cpu_done_q, vic_ack_q, ldr_ack_q, overrun_q;

    logic take_cpu, pulse_busy, gnt, pick_ldr;

    // Requests are level-held until ack, so a request is still visible in its
    // own ack cycle; arbitrating then would re-grant a finished access.
    always_comb begin
        take_cpu   = cpu_slot && (state_q == IDLE || state_q == DMA_ACC || state_q == DMA_CAP);
        pulse_busy = cpu_done_q || vic_ack_q || ldr_ack_q;
        pick_ldr   = ldr_req && (!vic_req || prio_ldr_q);
        gnt        = (state_q == IDLE) && !cpu_slot && !pulse_busy &&
                     (phase_q <= LIMIT) && (vic_req || ldr_req);
        if (cpu_slot)
            phase_d = PW'(1);
        else if (phase_q == LAST)
            phase_d = '0;
        else
            phase_d = phase_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            prio_ldr_q  <= 1'b0;
            owner_ldr_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_din_q   <= '0;
            cpu_rdata_q <= '0;
            vic_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            vic_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cpu_done_q <= 1'b0;
            vic_ack_q  <= 1'b0;
            ldr_ack_q  <= 1'b0;
            overrun_q  <= cpu_slot && (state_q != IDLE);
            phase_q    <= phase_d;
            if (take_cpu) begin
                state_q    <= CPU_ACC;
                ram_addr_q <= cpu_addr;
                ram_we_q   <= cpu_we;
                ram_din_q  <= cpu_wdata;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (gnt) begin
                            state_q     <= DMA_ACC;
                            owner_ldr_q <= pick_ldr;
                            ram_addr_q  <= pick_ldr ? ldr_addr : vic_addr;
                            ram_we_q    <= pick_ldr;
                            ram_din_q   <= pick_ldr ? ldr_wdata : 8'h00;
                        end
                    end
                    CPU_ACC: begin
                        ram_we_q <= 1'b0;
                        state_q  <= CPU_CAP;
                    end
                    CPU_CAP: begin
                        cpu_rdata_q <= ram_dout;
                        cpu_done_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                    DMA_ACC: begin
                        ram_we_q <= 1'b0;
                        state_q  <= DMA_CAP;
                    end
                    DMA_CAP: begin
                        if (owner_ldr_q) begin
                            ldr_ack_q  <= 1'b1;
                            prio_ldr_q <= 1'b0;
                        end else begin
                            vic_rdata_q <= ram_dout;
                            vic_ack_q   <= 1'b1;
                            prio_ldr_q  <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign vic_ack   = vic_ack_q;
    assign vic_rdata = vic_rdata_q;
    assign ldr_ack   = ldr_ack_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_din   = ram_din_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;
    assign dbg_phase = phase_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have a single clock `clk`; reset is synchronous and active-high (`reset`).
REQ-002 The block SHALL have parameter PERIOD, default 25: nominal clk cycles between CPU slots.
REQ-003 The block SHALL have parameter GUARD, default 3: minimum free cycles before the next expected CPU slot.
REQ-004 clk  in  1  system clock (25 MHz).
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cpu_slot  in  1  one-cycle CPU access strobe (cpu_clken).
REQ-007 cpu_addr  in  16, cpu_we  in  1, cpu_wdata  in  8: CPU access; sampled in the cpu_slot cycle.
REQ-008 cpu_rdata  out  8, cpu_done  out  1: CPU read data; one-cycle completion pulse.
REQ-009 vic_req  in  1, vic_addr  in  16: video fetch request (read-only), level-held until ack.
REQ-010 vic_ack  out  1, vic_rdata  out  8: video completion pulse and data.
REQ-011 ldr_req  in  1, ldr_addr  in  16, ldr_wdata  in  8: loader write request, level-held until ack.
REQ-012 ldr_ack  out  1: loader completion pulse.
REQ-013 ram_addr  out  16, ram_we  out  1, ram_din  out  8, ram_dout  in  8: shared RAM port (synchronous RAM, 1-cycle read latency).
REQ-014 overrun  out  1: one-cycle pulse on a CPU slot timing violation.

Function
REQ-015 The block SHALL use states IDLE, CPU_ACC, CPU_CAP, DMA_ACC and DMA_CAP; all RAM-port outputs SHALL be registered.
REQ-016 On cpu_slot in IDLE, the block SHALL latch the cpu_* inputs into ram_* and enter CPU_ACC, then CPU_CAP, then IDLE.
REQ-017 ram_we SHALL be high only in CPU_ACC or DMA_ACC, and only for a write access.
REQ-018 At the end of CPU_CAP, the block SHALL load cpu_rdata from ram_dout and pulse cpu_done in the next cycle: cpu_slot at cycle N gives cpu_done at N+3, for reads and writes.
REQ-019 The phase counter SHALL be 0 in the cpu_slot cycle, SHALL increment each cycle, and SHALL wrap PERIOD-1 to 0 when no slot arrives.
REQ-020 A DMA grant SHALL occur only in IDLE, with cpu_slot low and phase <= PERIOD-GUARD.
REQ-021 A DMA grant SHALL latch the requester address/data into ram_* and enter DMA_ACC, then DMA_CAP, then IDLE.
REQ-022 The ack pulse SHALL be issued in the cycle after DMA_CAP; vic_rdata SHALL be loaded from ram_dout at the end of DMA_CAP.
REQ-023 When vic_req and ldr_req are both asserted at grant time, the block SHALL grant the requester not completed most recently; after reset, VIC wins.
REQ-024 The round-robin pointer SHALL update only on a completed (acked) access.
REQ-025 A requester that drops req before ack SHALL still complete its in-flight access, and the ack SHALL be issued.
REQ-026 cpu_slot during DMA_ACC/DMA_CAP SHALL preempt: the next state SHALL be CPU_ACC with cpu_* latched, the DMA access abandoned with no ack, overrun pulsed, and the requester re-arbitrated later.
REQ-027 A preempted loader write MAY be re-issued, with identical data.
REQ-028 cpu_slot during CPU_ACC/CPU_CAP SHALL be dropped, with overrun pulsed and the phase counter still forced to 0.
REQ-029 ack and done pulses SHALL each be exactly one cycle, with at most one of cpu_done/vic_ack/ldr_ack per cycle.

Reset
REQ-030 While reset is high, the block SHALL hold: state IDLE, phase 0, round-robin pointer to VIC, all ram_* outputs 0, and cpu_rdata/vic_rdata 0.
REQ-031 While reset is high, the block SHALL hold cpu_done, vic_ack, ldr_ack and overrun at 0.
REQ-032 Reset asserted mid-access SHALL abandon the access with no ack; the first grant after reset SHALL be allowed no earlier than the cycle after reset deasserts.

Verification
REQ-033 RAM[0x1000]=0xA5; cpu_slot at N with cpu_addr=0x1000, cpu_we=0 -> ram_addr=0x1000 at N+1, cpu_done and cpu_rdata=0xA5 at N+3.
REQ-034 vic_req=ldr_req=1 held continuously after reset -> grants alternate VIC, LDR, VIC...; no DMA_ACC starts at phase > 22; no overrun.
REQ-035 ldr_req at phase 23 (addr=0x2000, data=0x3C) -> no grant until after the next CPU slot; granted at phase 4; ldr_ack at phase 7; RAM[0x2000]=0x3C.
REQ-036 Forced cpu_slot during DMA_ACC of a VIC fetch -> overrun=1 for one cycle; CPU completes at N+3; VIC re-granted later and acked exactly once.
REQ-037 reset pulsed during CPU_CAP -> no cpu_done; all outputs 0 next cycle; normal CPU access works afterwards.
REQ-038 Two cpu_slot pulses 2 cycles apart -> second dropped; overrun pulse; exactly one cpu_done.
